// File: rtl/qdiv_signed_seq.sv
// rtl/qdiv_signed_seq.sv - signed fixed-point restoring divider, one quotient bit per clock
// Start/valid handshake, optional round-half-away, saturation and divide-by-zero flags.
module qdiv_signed_seq #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             valid,
    output logic             busy,
    output logic             div_zero,
    output logic             overflow
);

    localparam int N  = WIDTH + FBITS + ROUND;
    localparam int CW = $clog2(N + 1);

    localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [N-1:0]     MAX_POS = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [N-1:0]     MIN_MAG = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     num_q, num_d;
    logic [N-1:0]     raw_q, raw_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic             dz_neg_q, dz_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic             take;
    logic [N-1:0]     mag;
    logic             sat_pos, sat_neg;

    always_comb begin
        // |min| = 2^(WIDTH-1) still fits when read back as unsigned
        a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
        shifted = {rem_q, num_q[N-1]};
        take    = (shifted >= {1'b0, dvs_q});
        if (ROUND != 0) begin
            mag = (raw_q >> 1) + {{(N-1){1'b0}}, raw_q[0]};
        end else begin
            mag = raw_q;
        end
        sat_pos = !neg_q && (mag > MAX_POS);
        sat_neg =  neg_q && (mag > MIN_MAG);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        raw_d     = raw_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        dz_pend_d = 1'b0;
        dz_neg_d  = dz_neg_q;
        quot_d    = quot_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        // A divide-by-zero accepted last edge reports now, independent of the FSM
        if (dz_pend_q) begin
            valid_d = 1'b1;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = dz_neg_q ? MIN_Q : MAX_Q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dz_pend_d = 1'b1;
                        dz_neg_d  = dividend[WIDTH-1];
                    end else begin
                        num_d   = {a_mag, {(FBITS+ROUND){1'b0}}};
                        dvs_d   = b_mag;
                        neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        cnt_d   = '0;
                        rem_d   = '0;
                        raw_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = take ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
                raw_d = {raw_q[N-2:0], take};
                num_d = {num_q[N-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (sat_pos) begin
                    quot_d = MAX_Q;
                    ovf_d  = 1'b1;
                end else if (sat_neg) begin
                    quot_d = MIN_Q;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
                    ovf_d  = 1'b0;
                end
                dz_d    = 1'b0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            raw_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            dz_pend_q <= 1'b0;
            dz_neg_q  <= 1'b0;
            quot_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            raw_q     <= raw_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            dz_pend_q <= dz_pend_d;
            dz_neg_q  <= dz_neg_d;
            quot_q    <= quot_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign quotient = quot_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign div_zero = dz_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_qdiv_signed_seq.sv
// tb/tb_qdiv_signed_seq.sv - bench for qdiv_signed_seq, truncating and rounding instances
// Arithmetic reference model with per-cycle compare, plus literal expectations.
module tb_qdiv_signed_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i [2];
    logic [31:0] a_i     [2];
    logic [31:0] b_i     [2];
    logic [31:0] q_o     [2];
    logic        v_o     [2];
    logic        busy_o  [2];
    logic        dz_o    [2];
    logic        ov_o    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qdiv_signed_seq #(.WIDTH(32), .FBITS(16), .ROUND(0)) u_trunc (
        .clk(clk), .rst(rst), .start(start_i[0]), .dividend(a_i[0]), .divisor(b_i[0]),
        .quotient(q_o[0]), .valid(v_o[0]), .busy(busy_o[0]), .div_zero(dz_o[0]), .overflow(ov_o[0])
    );

    qdiv_signed_seq #(.WIDTH(32), .FBITS(16), .ROUND(1)) u_round (
        .clk(clk), .rst(rst), .start(start_i[1]), .dividend(a_i[1]), .divisor(b_i[1]),
        .quotient(q_o[1]), .valid(v_o[1]), .busy(busy_o[1]), .div_zero(dz_o[1]), .overflow(ov_o[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Real-valued intent: q = a/b scaled by 2^16, truncated or rounded half away from zero
    function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit rnd);
        longint sa, sb, ma, mb, num, mag, r;
        bit neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        num = ma * 65536;
        mag = rnd ? (2 * num + mb) / (2 * mb) : num / mb;
        if (!neg && mag > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (neg && mag > 64'sd2147483648) return {1'b1, 32'h80000000};
        r = neg ? -mag : mag;
        return {1'b0, r[31:0]};
    endfunction

    logic        m_busy  [2];
    int          m_cnt   [2];
    logic        m_dzp   [2];
    logic [31:0] m_dzq   [2];
    logic [31:0] m_pq    [2];
    logic        m_pov   [2];
    logic        m_valid [2];
    logic [31:0] m_q     [2];
    logic        m_ov    [2];
    logic        m_dz    [2];
    bit          seen_rst = 1'b0;

    // Compare current outputs, then advance the model across the coming edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic acc;
            logic nv;
            logic [32:0] r;
            if (seen_rst) begin
                chk("valid", d, {31'b0, v_o[d]}, {31'b0, m_valid[d]});
                chk("busy", d, {31'b0, busy_o[d]}, {31'b0, m_busy[d]});
                chk("quotient", d, q_o[d], m_q[d]);
                chk("overflow", d, {31'b0, ov_o[d]}, {31'b0, m_ov[d]});
                chk("div_zero", d, {31'b0, dz_o[d]}, {31'b0, m_dz[d]});
            end
            if (rst) begin
                m_busy[d] = 1'b0; m_dzp[d] = 1'b0; m_valid[d] = 1'b0;
                m_q[d] = '0; m_ov[d] = 1'b0; m_dz[d] = 1'b0; m_cnt[d] = 0;
                seen_rst = 1'b1;
            end else begin
                nv  = 1'b0;
                acc = start_i[d] && !m_busy[d];
                if (m_dzp[d]) begin
                    nv = 1'b1; m_q[d] = m_dzq[d]; m_ov[d] = 1'b0; m_dz[d] = 1'b1; m_dzp[d] = 1'b0;
                end
                if (m_busy[d]) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        nv = 1'b1; m_q[d] = m_pq[d]; m_ov[d] = m_pov[d]; m_dz[d] = 1'b0; m_busy[d] = 1'b0;
                    end
                end
                if (acc) begin
                    if (b_i[d] == 32'd0) begin
                        m_dzp[d] = 1'b1;
                        m_dzq[d] = a_i[d][31] ? 32'h80000000 : 32'h7FFFFFFF;
                    end else begin
                        r = model_div(a_i[d], b_i[d], d == 1);
                        m_busy[d] = 1'b1;
                        m_cnt[d]  = (d == 1) ? 50 : 49;
                        m_pq[d]   = r[31:0];
                        m_pov[d]  = r[32];
                    end
                end
                m_valid[d] = nv;
            end
        end
    end

    task automatic wait_valid(input int d, inout int lat);
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!v_o[d] && lat < 200);
        if (!v_o[d]) begin
            errors++;
            $display("FAIL timeout dut%0d no valid after %0d cycles", d, lat);
        end
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(posedge clk); #1;
        start_i[d] = 1'b1; a_i[d] = a; b_i[d] = b;
        @(posedge clk); #1;
        start_i[d] = 1'b0; a_i[d] = $urandom; b_i[d] = $urandom;
        lat = 0;
        wait_valid(d, lat);
    endtask

    task automatic lit(input int d, input string nm, input int lat, input int lat_exp,
                       input logic [31:0] q, input logic ov, input logic dz);
        chk({nm, "_lat"}, d, lat, lat_exp);
        chk({nm, "_q"}, d, q_o[d], q);
        chk({nm, "_ov"}, d, {31'b0, ov_o[d]}, {31'b0, ov});
        chk({nm, "_dz"}, d, {31'b0, dz_o[d]}, {31'b0, dz});
    endtask

    initial begin
        int lat;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0; a_i[d] = '0; b_i[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_q", d, q_o[d], 32'h0);
            chk("rst_valid", d, {31'b0, v_o[d]}, 32'h0);
            chk("rst_busy", d, {31'b0, busy_o[d]}, 32'h0);
        end
        rst = 1'b0;

        run_op(0, 32'h00060000, 32'h00020000, lat); lit(0, "six_by_two", lat, 49, 32'h00030000, 0, 0);
        run_op(0, 32'hFFFF0000, 32'h00030000, lat); lit(0, "neg_third", lat, 49, 32'hFFFFAAAB, 0, 0);
        run_op(1, 32'h00000001, 32'h00020000, lat); lit(1, "half_up", lat, 50, 32'h00000001, 0, 0);
        run_op(0, 32'h00000001, 32'h00020000, lat); lit(0, "half_trunc", lat, 49, 32'h00000000, 0, 0);
        run_op(1, 32'hFFFFFFFF, 32'h00020000, lat); lit(1, "half_neg", lat, 50, 32'hFFFFFFFF, 0, 0);
        run_op(0, 32'h7FFF0000, 32'h00008000, lat); lit(0, "ovf_pos", lat, 49, 32'h7FFFFFFF, 1, 0);
        run_op(0, 32'h80000000, 32'hFFFF0000, lat); lit(0, "min_by_m1", lat, 49, 32'h7FFFFFFF, 1, 0);
        run_op(1, 32'h80000000, 32'h00010000, lat); lit(1, "min_by_1", lat, 50, 32'h80000000, 0, 0);
        run_op(0, 32'hFFFE0000, 32'h00000000, lat); lit(0, "dz_neg", lat, 1, 32'h80000000, 0, 1);
        run_op(1, 32'h00010000, 32'h00000000, lat); lit(1, "dz_pos", lat, 1, 32'h7FFFFFFF, 0, 1);

        // Back-to-back: start held through the valid cycle, operands changed while busy
        @(posedge clk); #1;
        start_i[0] = 1'b1; a_i[0] = 32'hFFFF0000; b_i[0] = 32'h00030000;
        @(posedge clk); #1;
        a_i[0] = 32'h00060000; b_i[0] = 32'h00020000;
        repeat (49) @(posedge clk);
        #1;
        chk("b2b_first_valid", 0, {31'b0, v_o[0]}, 32'h1);
        chk("b2b_first_q", 0, q_o[0], 32'hFFFFAAAB);
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        chk("b2b_busy", 0, {31'b0, busy_o[0]}, 32'h1);
        lat = 0;
        wait_valid(0, lat);
        lit(0, "b2b_second", lat, 49, 32'h00030000, 0, 0);

        // Start pulse mid-operation is ignored
        @(posedge clk); #1;
        start_i[0] = 1'b1; a_i[0] = 32'h00060000; b_i[0] = 32'h00020000;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_i[0] = 1'b1; a_i[0] = 32'h00010000; b_i[0] = 32'h00000000;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        lat = 5;
        wait_valid(0, lat);
        lit(0, "ignored_start", lat, 49, 32'h00030000, 0, 0);

        // Reset mid-operation aborts with no later valid
        @(posedge clk); #1;
        start_i[1] = 1'b1; a_i[1] = 32'h00060000; b_i[1] = 32'h00020000;
        @(posedge clk); #1;
        start_i[1] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 1, {31'b0, busy_o[1]}, 32'h0);
        chk("abort_valid", 1, {31'b0, v_o[1]}, 32'h0);
        chk("abort_q", 1, q_o[1], 32'h0);
        repeat (60) @(posedge clk);
        run_op(1, 32'h00050000, 32'h00020000, lat); lit(1, "after_rst", lat, 50, 32'h00028000, 0, 0);

        for (int i = 0; i < 160; i++) begin
            int d;
            logic [31:0] a, b;
            d = i % 2;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = $urandom_range(1, 255);
                2: b = 32'h80000000;
                3: b = {{16{b[31]}}, b[15:0]};
                4: a = 32'h80000000;
                5: a = {{12{a[31]}}, a[19:0]};
                default: ;
            endcase
            run_op(d, a, b, lat);
            chk("rand_lat", d, lat, (b == 32'h0) ? 1 : ((d == 1) ? 50 : 49));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
